// File: rtl/encryption_engine.sv
// encryption_engine: iterative AES-128 encryptor, one round per clock.
//
// Ports:
//   clk_i          sole clock, rising edge
//   reset_n_i      synchronous active-low reset
//   v_i / ready_o  block accept handshake (plaintext_i, key_i sampled when both high)
//   plaintext_i    128-bit plaintext, bit 127 is byte 0
//   key_i          128-bit cipher key, same byte order
//   v_o / yumi_i   ciphertext valid / consumer take
//   ciphertext_o   128-bit ciphertext, meaningful while v_o=1
//   count_o        completed-block count, only with ENCRYPT_BLOCK_COUNT_EN defined
//
// Optional feature macro: ENCRYPT_BLOCK_COUNT_EN
module encryption_engine (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [127:0] plaintext_i,
    input  logic [127:0] key_i,
    output logic         v_o,
    input  logic         yumi_i,
    output logic [127:0] ciphertext_o
`ifdef ENCRYPT_BLOCK_COUNT_EN
    ,output logic [31:0] count_o
`endif
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                         8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    state_t       fsm_r;
    logic         live_r;
    logic [127:0] state_r;
    logic [127:0] rkey_r;
    logic [3:0]   round_r;

    logic [127:0] w_sb, w_sr, w_mc, w_nk, w_next;
    logic [31:0]  w_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int k = 0; k < 16; k++)
            w_sb[127-8*k -: 8] = sbox(state_r[127-8*k -: 8]);
        // byte k sits at row k%4, column k/4; row r rotates left by r columns
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 8]  = xt(w_sr[127-32*c -: 8]) ^ xt(w_sr[119-32*c -: 8]) ^ w_sr[119-32*c -: 8]
                                 ^ w_sr[111-32*c -: 8] ^ w_sr[103-32*c -: 8];
            w_mc[119-32*c -: 8]  = w_sr[127-32*c -: 8] ^ xt(w_sr[119-32*c -: 8]) ^ xt(w_sr[111-32*c -: 8])
                                 ^ w_sr[111-32*c -: 8] ^ w_sr[103-32*c -: 8];
            w_mc[111-32*c -: 8]  = w_sr[127-32*c -: 8] ^ w_sr[119-32*c -: 8] ^ xt(w_sr[111-32*c -: 8])
                                 ^ xt(w_sr[103-32*c -: 8]) ^ w_sr[103-32*c -: 8];
            w_mc[103-32*c -: 8]  = xt(w_sr[127-32*c -: 8]) ^ w_sr[127-32*c -: 8] ^ w_sr[119-32*c -: 8]
                                 ^ w_sr[111-32*c -: 8] ^ xt(w_sr[103-32*c -: 8]);
        end
    end

    // next round key: SubWord(RotWord(w3)) ^ Rcon, then chained word XOR
    assign w_t = {sbox(rkey_r[23:16]) ^ RCON[round_r], sbox(rkey_r[15:8]), sbox(rkey_r[7:0]), sbox(rkey_r[31:24])};
    assign w_nk[127:96] = rkey_r[127:96] ^ w_t;
    assign w_nk[95:64]  = rkey_r[95:64] ^ w_nk[127:96];
    assign w_nk[63:32]  = rkey_r[63:32] ^ w_nk[95:64];
    assign w_nk[31:0]   = rkey_r[31:0] ^ w_nk[63:32];

    assign w_next = ((round_r == 4'd10) ? w_sr : w_mc) ^ w_nk;

    // live_r keeps ready_o low while reset is held and for the releasing edge
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            fsm_r   <= IDLE;
            live_r  <= 1'b0;
            state_r <= '0;
            rkey_r  <= '0;
            round_r <= '0;
        end else begin
            live_r <= 1'b1;
            case (fsm_r)
                IDLE: if (v_i && live_r) begin
                    state_r <= plaintext_i ^ key_i;
                    rkey_r  <= key_i;
                    round_r <= 4'd1;
                    fsm_r   <= ROUND;
                end
                ROUND: begin
                    state_r <= w_next;
                    rkey_r  <= w_nk;
                    round_r <= (round_r == 4'd10) ? round_r : round_r + 4'd1;
                    fsm_r   <= (round_r == 4'd10) ? DONE : ROUND;
                end
                DONE: if (yumi_i) fsm_r <= IDLE;
                default: fsm_r <= IDLE;
            endcase
        end
    end

    assign ready_o      = live_r && (fsm_r == IDLE);
    assign v_o          = (fsm_r == DONE);
    assign ciphertext_o = state_r;

`ifdef ENCRYPT_BLOCK_COUNT_EN
    logic [31:0] count_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            count_r <= '0;
        else if (fsm_r == DONE && yumi_i)
            count_r <= count_r + 32'd1;
    end

    assign count_o = count_r;
`endif
endmodule

// File: doc/encryption_engine.md
ENCRYPTION_ENGINE -- requirements
Module: encryption_engine

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds fixed.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n_i  input  1  synchronous, active-low reset.
REQ-004 v_i  input  1  plaintext/key valid.
REQ-005 ready_o  output  1  engine can accept a block.
REQ-006 plaintext_i  input  128  plaintext block; bit 127 is byte 0 (FIPS-197 order).
REQ-007 key_i  input  128  cipher key, same byte order.
REQ-008 v_o  output  1  ciphertext valid.
REQ-009 yumi_i  input  1  consumer takes ciphertext; legal only while v_o=1.
REQ-010 ciphertext_o  output  128  ciphertext block, same byte order.
REQ-011 count_o  output  32  completed-block count; present only with ENCRYPT_BLOCK_COUNT_EN.

Function
REQ-012 Iterative forward AES-128 cipher, one round per cycle, reusing existing sub_bytes, shift_rows, mix_columns, add_round_key blocks plus one shared round datapath.
REQ-013 FSM states IDLE, ROUND, DONE; ready_o=1 iff state=IDLE; v_o=1 iff state=DONE; both decoded from registers only.
REQ-014 IDLE: v_i=1 at an edge is the accept handshake; loads state_r <= plaintext_i XOR key_i, rkey_r <= key_i, round_r <= 1; goes to ROUND.
REQ-015 IDLE with v_i=0: no change.
REQ-016 ROUND: each edge applies SubBytes, ShiftRows, MixColumns, AddRoundKey(next key) to state_r; MixColumns bypassed when round_r=10.
REQ-017 Next key computed on the fly from rkey_r: RotWord, SubWord, XOR Rcon[round_r] (01,02,04,08,10,20,40,80,1b,36), word-chained XOR; result written to rkey_r in the same edge.
REQ-018 round_r is 4 bits, counts 1..10; at round_r=10 edge, FSM goes to DONE; round_r never wraps past 10.
REQ-019 Latency: handshake in cycle N -> v_o=1 from cycle N+11; round 1 at edge ending N+1, round 10 at edge ending N+10.
REQ-020 DONE: ciphertext_o and v_o held stable until yumi_i=1; yumi_i=1 -> IDLE next edge; ready_o=1 in the following cycle (12 cycles/block minimum).
REQ-021 v_i, plaintext_i, key_i ignored outside IDLE; inputs need not be held after the handshake.
REQ-022 yumi_i ignored outside DONE.
REQ-023 ciphertext_o = state_r at all times; content only meaningful while v_o=1.

Reset
REQ-024 reset_n_i=0 at an edge: state IDLE, state_r=0, rkey_r=0, round_r=0, count=0.
REQ-025 While reset_n_i=0: ready_o=0, v_o=0, ciphertext_o=0.
REQ-026 Reset in ROUND or DONE aborts the block; no v_o pulse for it; ready_o=1 in the first cycle after reset_n_i returns to 1.
REQ-027 Reset dominates simultaneous v_i or yumi_i.

Configuration
REQ-028 Macro ENCRYPT_BLOCK_COUNT_EN defined: 32-bit counter increments on each DONE->IDLE (yumi_i) transition, wraps 0xFFFFFFFF->0, drives count_o, cleared by reset.
REQ-029 Macro not defined: counter and count_o port absent; all other behaviour identical.

Verification
REQ-030 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, v_o rises exactly 11 cycles after handshake.
REQ-031 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; hold yumi_i=0 for 20 cycles -> ct and v_o stable, ready_o=0.
REQ-032 all-zero key and pt -> ct 66e94bd4ef8a2c3b884cfa59ca342b2e; toggle v_i and inputs during ROUND -> result unchanged.
REQ-033 Assert reset_n_i=0 at round 5 -> v_o never rises, ready_o=1 one cycle after release; next block (REQ-030 vector) correct.
REQ-034 Back-to-back: v_i held 1 with three vectors, yumi_i=1 whenever v_o -> three correct ciphertexts, 12-cycle spacing; with ENCRYPT_BLOCK_COUNT_EN count_o=3.
